frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//  Shares the symbol decoder (Fs/Fe/X0/One/Zero rails + per-rail acks) between two channel requesters.
//  Arbitrates round-robin, then serialises one 5-symbol command frame over a 4-phase req/ack handshake per symbol.
//  Frame = Fs, channel bit, X0, direction bit, Fe.
//  Sits between the channel command sources and the decoder; owns the decoder's input rails exclusively.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles waited in any handshake phase before error (1..2^TO_W-1)
//  TO_W         8    timeout counter width
//  GAP_CYCLES   2    idle cycles forced between consecutive frames (0 allowed)
// PORTS
//  clk        in   1  single clock, all logic rising-edge
//  rst        in   1  synchronous, active-high reset
//  ch1_req    in   1  channel 1 wants a frame; hold high until ch1_grant
//  ch1_dir    in   1  channel 1 direction: 1=Up, 0=Down; sampled at grant decision
//  ch2_req    in   1  channel 2 request, same rules
//  ch2_dir    in   1  channel 2 direction
//  ch1_grant  out  1  1-cycle pulse: ch1 frame fully acknowledged
//  ch2_grant  out  1  1-cycle pulse: ch2 frame fully acknowledged
//  Fs,Fe,X0,One,Zero  out 1 each  symbol rails to decoder; registered; at most one high
//  Fs_ack,Fe_ack,X0_ack,one_ack,zero_ack  in 1 each  decoder acks; asynchronous to clk
//  busy       out  1  high in any state except IDLE
//  err        out  1  sticky: timeout or protocol error
//  err_clr    in   1  clears err and leaves ERR state
// BEHAVIOUR
//  Reset: all rails 0, grants 0, busy 0, err 0, state IDLE, rr pointer = ch2 (ch1 wins first tie).
//  Reset mid-frame aborts the frame: rails 0 after that edge, no grant issued.
//  Acks pass through 2-flop synchronisers; the FSM sees only synchronised acks (2-cycle latency).
//  States:
//   IDLE:  if any req, pick winner. Both requesting: winner != rr pointer.
//          Latch chan and dir, load symbol index 0, go S_HI.
//          First rail (Fs) is high the cycle after req is first sampled.
//   S_HI:  drive rail of current symbol; wait for its synced ack = 1, then go S_LO.
//          Rail drops on the 3rd rising edge after the raw ack rises.
//   S_LO:  rails all 0; wait for synced ack = 0.
//          Then: index < 4 -> index+1, S_HI; index == 4 -> DONE.
//   DONE:  1-cycle grant pulse to latched chan; rr pointer = chan; go GAP (or IDLE if GAP_CYCLES = 0).
//   GAP:   count GAP_CYCLES, then IDLE.
//   ERR:   rails 0, err = 1, no grant; the frame is dropped, not retried.
//          err_clr = 1 and all synced acks = 0 -> IDLE.
//  Symbol map (index 0..4):
//   0 = Fs
//   1 = chan (Zero = ch1, One = ch2)
//   2 = X0
//   3 = dir (One = Up, Zero = Down)
//   4 = Fe
//  Timeout: counter clears on entry to S_HI/S_LO and increments each cycle in them.
//   Reaching ACK_TIMEOUT -> ERR. Saturating; no wrap.
//  Protocol error: in S_HI/S_LO, any synced ack other than the current symbol's is high -> ERR.
//  Requests are ignored while busy; a req dropped before grant still completes its frame.
//  ch*_dir changes after the frame is latched have no effect.
//  Rails are mutually exclusive in every cycle (assertion in bench).
// TESTING
//  1. Ack model acks 1 cycle after rail, releases 1 cycle after drop; ch1_req = 1, dir = 0
//     -> rails Fs, Zero, X0, Zero, Fe in order; one ch1_grant pulse; busy low after 2 GAP cycles.
//  2. ch1_req and ch2_req high together, both dir = 1, held after grants
//     -> ch1 frame, then ch2 frame (Fs, One, X0, One, Fe), then ch1 again; grants alternate.
//  3. Ack model never acks Fs, ACK_TIMEOUT = 8
//     -> err = 1 exactly 8 cycles after S_HI entry; rails 0; no grant; err_clr -> busy = 0.
//  4. During the One symbol, model raises X0_ack
//     -> ERR, err = 1, rails 0, frame dropped.
//  5. rst pulsed while X0 is high
//     -> X0 = 0 next edge; all outputs at reset values; no grant.
//     Then a new req runs a full frame normally.
//  6. ch2_dir toggled every cycle after grant decision
//     -> transmitted dir bit equals the value sampled in IDLE.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Shares one symbol decoder between two channel requesters. A round-robin
// arbiter picks a channel. The block then sends one 5-symbol command frame
// (Fs, channel bit, X0, direction bit, Fe) over the decoder's rails. Each
// symbol uses a 4-phase req/ack handshake.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   ch1_req/ch1_dir, ch2_req/ch2_dir : channel requests and direction bits
//   ch1_grant, ch2_grant          : 1-cycle pulse when a frame is fully acked
//   Fs, Fe, X0, One, Zero         : registered symbol rails, at most one high
//   Fs_ack .. zero_ack            : decoder acks, asynchronous to clk
//   busy                          : high whenever not IDLE
//   err, err_clr                  : sticky error flag and its clear
module frame_scheduler #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ch1_req,
    input  logic ch1_dir,
    input  logic ch2_req,
    input  logic ch2_dir,
    output logic ch1_grant,
    output logic ch2_grant,
    output logic Fs,
    output logic Fe,
    output logic X0,
    output logic One,
    output logic Zero,
    input  logic Fs_ack,
    input  logic Fe_ack,
    input  logic X0_ack,
    input  logic one_ack,
    input  logic zero_ack,
    output logic busy,
    output logic err,
    input  logic err_clr
);

    typedef enum logic [2:0] {IDLE, S_HI, S_LO, DONE, GAP, ERR} state_t;

    // The last counter values before a phase ends. The timer and the
    // inter-frame gap share one counter.
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] GAP_LAST = TO_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic [2:0]      symIdx_q, symIdx_d;
    logic            chan_q, chan_d;
    logic            dir_q, dir_d;
    logic            rrPtr_q, rrPtr_d;
    logic [TO_W-1:0] timer_q, timer_d, timerInc;
    logic [4:0]      rails_q, rails_d;
    logic [4:0]      ackMeta_q, ackSync_q;
    logic            err_q;
    logic [4:0]      ackRaw, curMask;
    logic            curAck, otherAck;

    // Rail and ack vectors share one bit order: {Fs, Fe, X0, One, Zero}.
    function automatic logic [4:0] symbolRail(input logic [2:0] idx,
                                              input logic chan,
                                              input logic dir);
        case (idx)
            3'd0:    symbolRail = 5'b10000;
            3'd1:    symbolRail = chan ? 5'b00010 : 5'b00001;
            3'd2:    symbolRail = 5'b00100;
            3'd3:    symbolRail = dir ? 5'b00010 : 5'b00001;
            3'd4:    symbolRail = 5'b01000;
            default: symbolRail = 5'b00000;
        endcase
    endfunction

    assign ackRaw   = {Fs_ack, Fe_ack, X0_ack, one_ack, zero_ack};
    assign curMask  = symbolRail(symIdx_q, chan_q, dir_q);
    assign curAck   = |(ackSync_q & curMask);
    assign otherAck = |(ackSync_q & ~curMask);
    assign timerInc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    // Next-state logic. A stray ack from another rail takes priority over
    // normal progress, so a misbehaving decoder is never accepted.
    always_comb begin
        state_d  = state_q;
        symIdx_d = symIdx_q;
        chan_d   = chan_q;
        dir_d    = dir_q;
        rrPtr_d  = rrPtr_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (ch1_req || ch2_req) begin
                    // On a tie the channel not served last wins.
                    chan_d   = (ch1_req && ch2_req) ? ~rrPtr_q : ch2_req;
                    dir_d    = chan_d ? ch2_dir : ch1_dir;
                    symIdx_d = 3'd0;
                    timer_d  = '0;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (otherAck) begin
                    state_d = ERR;
                end else if (curAck) begin
                    timer_d = '0;
                    state_d = S_LO;
                end else if (timer_q >= TO_LAST) begin
                    state_d = ERR;
                end else begin
                    timer_d = timerInc;
                end
            end
            S_LO: begin
                if (otherAck) begin
                    state_d = ERR;
                end else if (!curAck) begin
                    if (symIdx_q == 3'd4) begin
                        state_d = DONE;
                    end else begin
                        symIdx_d = symIdx_q + 3'd1;
                        timer_d  = '0;
                        state_d  = S_HI;
                    end
                end else if (timer_q >= TO_LAST) begin
                    state_d = ERR;
                end else begin
                    timer_d = timerInc;
                end
            end
            DONE: begin
                rrPtr_d = chan_q;
                timer_d = '0;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (timer_q >= GAP_LAST) state_d = IDLE;
                else                     timer_d = timerInc;
            end
            ERR: begin
                if (err_clr && (ackSync_q == 5'b00000)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Rails are registered from the next state. A rail therefore rises on the
    // edge that enters S_HI and falls on the edge that leaves it.
    assign rails_d = (state_d == S_HI) ? symbolRail(symIdx_d, chan_d, dir_d) : 5'b00000;

    // State registers and the ack synchronisers. The synchronisers are
    // cleared too, so a reset never leaves a stale ack in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            symIdx_q  <= 3'd0;
            chan_q    <= 1'b0;
            dir_q     <= 1'b0;
            rrPtr_q   <= 1'b1;
            timer_q   <= '0;
            rails_q   <= 5'b00000;
            ackMeta_q <= 5'b00000;
            ackSync_q <= 5'b00000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            symIdx_q  <= symIdx_d;
            chan_q    <= chan_d;
            dir_q     <= dir_d;
            rrPtr_q   <= rrPtr_d;
            timer_q   <= timer_d;
            rails_q   <= rails_d;
            ackMeta_q <= ackRaw;
            ackSync_q <= ackMeta_q;
            err_q     <= (state_d == ERR);
        end
    end

    assign {Fs, Fe, X0, One, Zero} = rails_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign ch1_grant = (state_q == DONE) && !chan_q;
    assign ch2_grant = (state_q == DONE) && chan_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
// Directed bench for frame_scheduler. A clocked ack model answers each rail
// one cycle after the rail rises. It can also stay silent or raise a stray
// ack. A negedge monitor records the rising rails and checks that the rails
// are mutually exclusive.
module tb_frame_scheduler;

    localparam logic [4:0] SYM_FS   = 5'b10000;
    localparam logic [4:0] SYM_FE   = 5'b01000;
    localparam logic [4:0] SYM_X0   = 5'b00100;
    localparam logic [4:0] SYM_ONE  = 5'b00010;
    localparam logic [4:0] SYM_ZERO = 5'b00001;

    localparam logic [31:0] F_CH1_DN = {7'b0, SYM_FS, SYM_ZERO, SYM_X0, SYM_ZERO, SYM_FE};
    localparam logic [31:0] F_CH1_UP = {7'b0, SYM_FS, SYM_ZERO, SYM_X0, SYM_ONE,  SYM_FE};
    localparam logic [31:0] F_CH2_UP = {7'b0, SYM_FS, SYM_ONE,  SYM_X0, SYM_ONE,  SYM_FE};

    logic clk = 1'b0;
    logic rst, ch1_req, ch1_dir, ch2_req, ch2_dir, err_clr;
    logic ch1_grant, ch2_grant, Fs, Fe, X0, One, Zero, busy, err;
    logic Fs_ack, Fe_ack, X0_ack, one_ack, zero_ack;

    logic [4:0] ackVec = 5'b00000;
    logic [4:0] railsSeen;
    int         ackMode = 0;

    logic [4:0] symQ[$];
    logic [4:0] prevRails = 5'b00000;
    logic [4:0] curRails;
    int         exclViol = 0;
    int         g1Total = 0, g2Total = 0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    frame_scheduler #(.ACK_TIMEOUT(8), .TO_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ch1_req(ch1_req), .ch1_dir(ch1_dir), .ch2_req(ch2_req), .ch2_dir(ch2_dir),
        .ch1_grant(ch1_grant), .ch2_grant(ch2_grant),
        .Fs(Fs), .Fe(Fe), .X0(X0), .One(One), .Zero(Zero),
        .Fs_ack(Fs_ack), .Fe_ack(Fe_ack), .X0_ack(X0_ack), .one_ack(one_ack), .zero_ack(zero_ack),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    assign {Fs_ack, Fe_ack, X0_ack, one_ack, zero_ack} = ackVec;

    // Decoder model. It samples the rails as they stood before this edge and
    // answers shortly after the edge. Mode 0 echoes the rails, mode 1 never
    // acks, and mode 2 adds a stray X0 ack whenever One is driven.
    always @(posedge clk) begin
        railsSeen = {Fs, Fe, X0, One, Zero};
        #1;
        case (ackMode)
            1:       ackVec = 5'b00000;
            2:       ackVec = railsSeen | (railsSeen[1] ? SYM_X0 : 5'b00000);
            default: ackVec = railsSeen;
        endcase
    end

    // Monitor for rail rises, rail exclusivity and grant pulses.
    always @(negedge clk) begin
        curRails = {Fs, Fe, X0, One, Zero};
        if ($countones(curRails) > 1) exclViol++;
        if ((curRails & ~prevRails) != 5'b00000) symQ.push_back(curRails & ~prevRails);
        prevRails = curRails;
        if (ch1_grant) g1Total++;
        if (ch2_grant) g2Total++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frameAt(input int start);
        logic [31:0] f = 32'h0;
        if (symQ.size() < start + 5) return 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) f = (f << 5) | {27'b0, symQ[start + i]};
        return f;
    endfunction

    task automatic applyStimulus(input logic r1, input logic d1, input logic r2, input logic d2);
        ch1_req = r1;
        ch1_dir = d1;
        ch2_req = r2;
        ch2_dir = d2;
    endtask

    task automatic applyReset();
        rst     = 1'b1;
        err_clr = 1'b0;
        ackMode = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitForGrant(input int maxCycles, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (ch1_grant || ch2_grant) begin
                g = {ch2_grant, ch1_grant};
                break;
            end
        end
    endtask

    logic [1:0] g;
    int         qStart, g1Snap, g2Snap;

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyReset();

        // Reset values and a single ch1 Down frame
        checkOutput("rst_rails", {27'b0, Fs, Fe, X0, One, Zero}, 32'h0);
        checkOutput("rst_busy",  {31'b0, busy}, 32'h0);
        checkOutput("rst_err",   {31'b0, err}, 32'h0);
        checkOutput("rst_grant", {30'b0, ch2_grant, ch1_grant}, 32'h0);
        qStart = symQ.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_fs_first", {27'b0, Fs, Fe, X0, One, Zero}, {27'b0, SYM_FS});
        waitForGrant(200, g);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_grant", {30'b0, g}, 32'h1);
        checkOutput("t1_frame", frameAt(qStart), F_CH1_DN);
        @(negedge clk);
        checkOutput("t1_pulse", {30'b0, ch2_grant, ch1_grant}, 32'h0);
        checkOutput("t1_gap1_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        checkOutput("t1_gap2_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        checkOutput("t1_idle_busy", {31'b0, busy}, 32'h0);

        // Both channels held: grants alternate starting with ch1
        applyReset();
        qStart = symQ.size();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        waitForGrant(200, g);
        checkOutput("t2_grant_a", {30'b0, g}, 32'h1);
        checkOutput("t2_frame_a", frameAt(qStart), F_CH1_UP);
        waitForGrant(200, g);
        checkOutput("t2_grant_b", {30'b0, g}, 32'h2);
        checkOutput("t2_frame_b", frameAt(qStart + 5), F_CH2_UP);
        waitForGrant(200, g);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_grant_c", {30'b0, g}, 32'h1);
        checkOutput("t2_frame_c", frameAt(qStart + 10), F_CH1_UP);
        repeat (4) @(negedge clk);

        // Silent decoder: timeout exactly 8 cycles after entering S_HI
        applyReset();
        g1Snap = g1Total;
        g2Snap = g2Total;
        ackMode = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_fs", {31'b0, Fs}, 32'h1);
        repeat (7) @(negedge clk);
        checkOutput("t3_err_early", {31'b0, err}, 32'h0);
        @(negedge clk);
        checkOutput("t3_err", {31'b0, err}, 32'h1);
        checkOutput("t3_rails", {27'b0, Fs, Fe, X0, One, Zero}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("t3_err_sticky", {31'b0, err}, 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("t3_clr_busy", {31'b0, busy}, 32'h0);
        checkOutput("t3_clr_err",  {31'b0, err}, 32'h0);
        checkOutput("t3_no_grant", g1Total + g2Total - g1Snap - g2Snap, 32'h0);

        // Stray X0 ack during the One symbol: protocol error, frame dropped
        applyReset();
        g1Snap = g1Total;
        g2Snap = g2Total;
        qStart = symQ.size();
        ackMode = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err) break;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_err", {31'b0, err}, 32'h1);
        checkOutput("t4_rails", {27'b0, Fs, Fe, X0, One, Zero}, 32'h0);
        checkOutput("t4_sym_count", symQ.size() - qStart, 32'd4);
        ackMode = 0;
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("t4_clr_busy", {31'b0, busy}, 32'h0);
        checkOutput("t4_no_grant", g1Total + g2Total - g1Snap - g2Snap, 32'h0);

        // Reset while X0 is driven aborts the frame; a fresh frame then runs
        applyReset();
        g1Snap = g1Total;
        g2Snap = g2Total;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (X0) break;
        end
        checkOutput("t5_x0_seen", {31'b0, X0}, 32'h1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_rails", {27'b0, Fs, Fe, X0, One, Zero}, 32'h0);
        checkOutput("t5_busy", {31'b0, busy}, 32'h0);
        checkOutput("t5_err", {31'b0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_no_grant", g1Total + g2Total - g1Snap - g2Snap, 32'h0);
        qStart = symQ.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitForGrant(200, g);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_grant", {30'b0, g}, 32'h1);
        checkOutput("t5_frame", frameAt(qStart), F_CH1_DN);

        // ch2_dir toggles every cycle after the grant decision
        applyReset();
        qStart = symQ.size();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        g = 2'b00;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ch1_grant || ch2_grant) begin
                g = {ch2_grant, ch1_grant};
                break;
            end
            ch2_dir = ~ch2_dir;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_grant", {30'b0, g}, 32'h2);
        checkOutput("t6_frame", frameAt(qStart), F_CH2_UP);
        repeat (4) @(negedge clk);

        checkOutput("rails_exclusive", exclViol, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Guard against a hang anywhere in the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
